multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM of the multicycle CPU; drives the datapath enables and muxes.
//  Produces BranchSel and PCWriteCond, which feed the branch mux (PC update when
//  (PCWriteCond & selected flag) | PCWrite), plus all other per-state controls.
//  Adds memory wait-state handshake (MemReady) and an illegal-opcode flag.
// PARAMETERS
//  IDLE_CYCLES  1  cycles spent in IDLE after reset release before first FETCH (>=1)
// PORTS
//  clk          in   1  rising-edge clock
//  rst_n        in   1  async active-low reset
//  Op           in   6  IR[31:26], valid from DECODE onward
//  MemReady     in   1  memory access completes this cycle
//  PCWrite      out  1  unconditional PC load
//  PCWriteCond  out  1  conditional PC load (branch)
//  BranchSel    out  1  0: BEQ (take on Zero), 1: BNE (take on !Zero)
//  IorD         out  1  0: PC addresses memory, 1: ALUOut
//  MemRead      out  1  memory read strobe
//  MemWrite     out  1  memory write strobe
//  IRWrite      out  1  instruction register load
//  MemtoReg     out  1  1: MDR to register write data
//  RegDst       out  1  1: rd, 0: rt
//  RegWrite     out  1  register file write
//  ALUSrcA      out  1  0: PC, 1: A
//  ALUSrcB      out  2  0: B, 1: const 4, 2: signext imm, 3: signext imm<<2
//  ALUOp        out  2  0: add, 1: sub, 2: funct field
//  PCSource     out  2  0: ALU result, 1: ALUOut, 2: jump target
//  Illegal      out  1  one-cycle pulse in DECODE on unknown Op
//  State        out  4  current state code (debug)
// BEHAVIOUR
//  States/codes: IDLE0 FETCH1 DECODE2 MEMADR3 MEMRD4 MEMWB5 MEMWR6 EXEC7 ALUWB8
//   BRANCH9 JUMP10 ADDIEX11 ADDIWB12; 13-15 unused -> next FETCH, all outputs 0.
//  Reset: rst_n low -> State=IDLE immediately; all outputs 0 while in IDLE.
//  IDLE: count IDLE_CYCLES, then FETCH.
//  FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0;
//   IRWrite=PCWrite=MemReady (qualified same cycle); stay until MemReady=1 -> DECODE.
//  DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0. Next by Op: 0x23/0x2B->MEMADR,
//   0x00->EXEC, 0x04/0x05->BRANCH, 0x02->JUMP, 0x08->ADDIEX, else Illegal=1 ->FETCH.
//  MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=0; Op 0x23->MEMRD, 0x2B->MEMWR.
//  MEMRD: MemRead=1, IorD=1; wait MemReady -> MEMWB.
//  MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
//  MEMWR: MemWrite=1, IorD=1; wait MemReady -> FETCH (MemWrite held every wait cycle).
//  EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2 -> ALUWB. ALUWB: RegWrite=1, RegDst=1,
//   MemtoReg=0 -> FETCH.
//  BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCSource=1, PCWriteCond=1,
//   BranchSel=Op[0] (0x04->0, 0x05->1) -> FETCH. BranchSel=0 in all other states.
//  JUMP: PCWrite=1, PCSource=2 -> FETCH.
//  ADDIEX: ALUSrcA=1, ALUSrcB=2, ALUOp=0 -> ADDIWB. ADDIWB: RegWrite=1, RegDst=0,
//   MemtoReg=0 -> FETCH.
//  Outputs not listed for a state are 0. Outputs are combinational from State
//   (plus MemReady in FETCH); no output asserted in two consecutive states unless listed.
//  Op sampled combinationally in DECODE/MEMADR/BRANCH; IR is stable there.
//  Reset mid-instruction: abort at once, no partial RegWrite/MemWrite after rst_n low.
//  Cycle counts, MemReady=1 always: R/ADDI 4, LW 5, SW 4, BEQ/BNE 3, J 3.
// TESTING
//  Reset release, MemReady=1 -> State 0 for 1 cycle, then 1; all outputs 0 in IDLE.
//  Op=0x23, MemReady=1 -> 1,2,3,4,5,1; RegWrite=1 & MemtoReg=1 only in state 5.
//  Op=0x2B, MemReady low 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, then FETCH.
//  Op=0x05 -> BRANCH with PCWriteCond=1, BranchSel=1; Op=0x04 -> BranchSel=0.
//  Op=0x3F -> Illegal=1 one cycle in DECODE, next State=1, no writes.
//  rst_n low during MEMRD wait -> State=0 without clock edge, MemRead=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle CPU: sequences fetch/decode/execute and
// drives datapath enables and mux selects, with a memory wait-state handshake.
module multicycle_ctrl #(
  parameter int IDLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchSel,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int CNT_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (idle_cnt_q == IDLE_LAST) state_d = S_FETCH;
        else                         idle_cnt_d = idle_cnt_q + 1'b1;
      end
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_RTYPE:        state_d = S_EXEC;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          OP_ADDI:         state_d = S_ADDIEX;
          default:         state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (Op == OP_LW) ? S_MEMRD : (Op == OP_SW) ? S_MEMWR : S_FETCH;
      S_MEMRD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWR:  if (MemReady) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Controls decode straight from the current state so reset clears them without a clock.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchSel   = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'd0;
    ALUOp       = 2'd0;
    PCSource    = 2'd0;
    Illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: begin
        ALUSrcB = 2'd3;
        Illegal = !(Op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_J, OP_ADDI});
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'd2;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'd1;
        PCSource    = 2'd1;
        PCWriteCond = 1'b1;
        BranchSel   = Op[0];
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'd2;
      end
      S_ADDIWB: RegWrite = 1'b1;
      default: ;
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through its
// state sequence and compares state code plus the full control word per cycle.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Op;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, BranchSel, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Illegal;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;

  int tests_run    = 0;
  int tests_failed = 0;

  multicycle_ctrl #(.IDLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchSel(BranchSel),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .Illegal(Illegal), .State(State)
  );

  always #5 clk = ~clk;

  // {PCW,PCWC,BSel,IorD,MR,MW,IRW,M2R,RDst,RW,SrcA,SrcB[2],ALUOp[2],PCSrc[2],Ill}
  logic [17:0] ctl;
  assign ctl = {PCWrite, PCWriteCond, BranchSel, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Illegal};

  localparam logic [17:0] C_ZERO    = 18'b0_0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [17:0] C_FETCH   = 18'b1_0_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [17:0] C_FWAIT   = 18'b0_0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [17:0] C_DECODE  = 18'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [17:0] C_DEC_ILL = 18'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [17:0] C_MEMADR  = 18'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [17:0] C_MEMRD   = 18'b0_0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [17:0] C_MEMWB   = 18'b0_0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [17:0] C_MEMWR   = 18'b0_0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [17:0] C_EXEC    = 18'b0_0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [17:0] C_ALUWB   = 18'b0_0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [17:0] C_BNE     = 18'b0_1_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [17:0] C_BEQ     = 18'b0_1_0_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [17:0] C_JUMP    = 18'b1_0_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [17:0] C_ADDIWB  = 18'b0_0_0_0_0_0_0_0_0_1_0_00_00_00_0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Lets combinational outputs settle, then compares state code and control word.
  task automatic expect_st(input string tag, input logic [3:0] st, input logic [17:0] c);
    #1;
    check({tag, ".state"}, {28'd0, State}, {28'd0, st});
    check({tag, ".ctl"}, {14'd0, ctl}, {14'd0, c});
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    Op       = 6'h00;
    MemReady = 1'b1;
    #2;
    expect_st("reset", 4'd0, C_ZERO);
    #9;
    rst_n = 1'b1;
    expect_st("idle_after_release", 4'd0, C_ZERO);
    cyc();

    // LW: 1,2,3,4,5,1
    Op = 6'h23;
    expect_st("lw_fetch", 4'd1, C_FETCH);
    cyc(); expect_st("lw_decode", 4'd2, C_DECODE);
    cyc(); expect_st("lw_memadr", 4'd3, C_MEMADR);
    cyc(); expect_st("lw_memrd", 4'd4, C_MEMRD);
    cyc(); expect_st("lw_memwb", 4'd5, C_MEMWB);
    cyc();

    // FETCH wait state, then SW with three MEMWR wait cycles
    Op = 6'h2B; MemReady = 1'b0;
    expect_st("fetch_wait", 4'd1, C_FWAIT);
    cyc(); expect_st("fetch_wait2", 4'd1, C_FWAIT);
    MemReady = 1'b1;
    expect_st("sw_fetch", 4'd1, C_FETCH);
    cyc(); expect_st("sw_decode", 4'd2, C_DECODE);
    cyc(); expect_st("sw_memadr", 4'd3, C_MEMADR);
    cyc(); MemReady = 1'b0; expect_st("sw_memwr1", 4'd6, C_MEMWR);
    cyc(); expect_st("sw_memwr2", 4'd6, C_MEMWR);
    cyc(); expect_st("sw_memwr3", 4'd6, C_MEMWR);
    cyc(); MemReady = 1'b1; expect_st("sw_memwr4", 4'd6, C_MEMWR);
    cyc();

    // BNE then BEQ
    Op = 6'h05;
    expect_st("bne_fetch", 4'd1, C_FETCH);
    cyc(); expect_st("bne_decode", 4'd2, C_DECODE);
    cyc(); expect_st("bne_branch", 4'd9, C_BNE);
    cyc(); Op = 6'h04;
    expect_st("beq_fetch", 4'd1, C_FETCH);
    cyc(); expect_st("beq_decode", 4'd2, C_DECODE);
    cyc(); expect_st("beq_branch", 4'd9, C_BEQ);
    cyc();

    // Illegal opcode: pulse in DECODE, straight back to FETCH
    Op = 6'h3F;
    expect_st("ill_fetch", 4'd1, C_FETCH);
    cyc(); expect_st("ill_decode", 4'd2, C_DEC_ILL);
    cyc();

    // R-type: 1,2,7,8
    Op = 6'h00;
    expect_st("r_fetch", 4'd1, C_FETCH);
    cyc(); expect_st("r_decode", 4'd2, C_DECODE);
    cyc(); expect_st("r_exec", 4'd7, C_EXEC);
    cyc(); expect_st("r_aluwb", 4'd8, C_ALUWB);
    cyc();

    // J: 1,2,10
    Op = 6'h02;
    expect_st("j_fetch", 4'd1, C_FETCH);
    cyc(); expect_st("j_decode", 4'd2, C_DECODE);
    cyc(); expect_st("j_jump", 4'd10, C_JUMP);
    cyc();

    // ADDI: 1,2,11,12
    Op = 6'h08;
    expect_st("addi_fetch", 4'd1, C_FETCH);
    cyc(); expect_st("addi_decode", 4'd2, C_DECODE);
    cyc(); expect_st("addi_ex", 4'd11, C_MEMADR);
    cyc(); expect_st("addi_wb", 4'd12, C_ADDIWB);
    cyc();

    // LW aborted by reset while waiting in MEMRD
    Op = 6'h23;
    expect_st("abort_fetch", 4'd1, C_FETCH);
    cyc(); expect_st("abort_decode", 4'd2, C_DECODE);
    cyc(); expect_st("abort_memadr", 4'd3, C_MEMADR);
    cyc(); MemReady = 1'b0; expect_st("abort_memrd", 4'd4, C_MEMRD);
    cyc(); expect_st("abort_memrd_wait", 4'd4, C_MEMRD);
    rst_n = 1'b0;
    expect_st("abort_async_reset", 4'd0, C_ZERO);
    MemReady = 1'b1;
    cyc(); expect_st("abort_held_reset", 4'd0, C_ZERO);
    rst_n = 1'b1;
    cyc(); expect_st("abort_refetch", 4'd1, C_FETCH);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
